// File: rtl/manager_pkg.sv
// Shared definitions for the manager arbiter: channel-count limits and the
// channel-ID width helper.
package manager_pkg;

  localparam int unsigned NChMin = 2;
  localparam int unsigned NChMax = 16;

  // Width of a channel ID; never narrower than one bit.
  function automatic int unsigned ch_id_w(input int unsigned n_ch);
    return (n_ch <= 2) ? 1 : $clog2(n_ch);
  endfunction

endpackage

// File: rtl/arb_ord_fifo.sv
// In-order channel-ID FIFO. It records which channel issued each
// outstanding core request so that replies can be steered back.
module arb_ord_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AW-1:0] LastPtr = AW'(Depth - 1);
  localparam logic [AW:0] FullCnt = (AW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_en, pop_en;

  assign full_o  = (cnt_q == FullCnt);
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_en) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_en) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({push_en, pop_en})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: it is only read while the count is non-zero.
  always_ff @(posedge clk_i) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/manager_arbiter.sv
// Round-robin merge of per-channel alloc/dealloc requests onto one allocator
// core, with in-order reply steering. Define MANAGER_ARB_ERR_EN for o_err.
module manager_arbiter
  import manager_pkg::*;
#(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned REQ_W     = 8,
  parameter int unsigned REP_W     = 8,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_CH-1:0]       s_req_alloc_vld,
  output logic [N_CH-1:0]       s_req_alloc_rdy,
  input  logic [N_CH*REQ_W-1:0] s_req_alloc_data,
  input  logic [N_CH-1:0]       s_req_dealloc_vld,
  output logic [N_CH-1:0]       s_req_dealloc_rdy,
  input  logic [N_CH*REP_W-1:0] s_req_dealloc_data,
  output logic                  m_req_alloc_vld,
  input  logic                  m_req_alloc_rdy,
  output logic [REQ_W-1:0]      m_req_alloc_data,
  output logic                  m_req_dealloc_vld,
  input  logic                  m_req_dealloc_rdy,
  output logic [REP_W-1:0]      m_req_dealloc_data,
  input  logic                  s_rep_alloc_vld,
  output logic                  s_rep_alloc_rdy,
  input  logic [REP_W-1:0]      s_rep_alloc_data,
  output logic [N_CH-1:0]       m_rep_alloc_vld,
  input  logic [N_CH-1:0]       m_rep_alloc_rdy,
  output logic [REP_W-1:0]      m_rep_alloc_data,
  input  logic                  s_rep_dealloc_vld,
  output logic                  s_rep_dealloc_rdy,
  input  logic [REP_W-1:0]      s_rep_dealloc_data,
  output logic [N_CH-1:0]       m_rep_dealloc_vld,
  input  logic [N_CH-1:0]       m_rep_dealloc_rdy,
  output logic [REP_W-1:0]      m_rep_dealloc_data,
  output logic                  o_err
);

  localparam int unsigned IDW = ch_id_w(N_CH);
  localparam logic [IDW-1:0] LastCh = IDW'(N_CH - 1);

  if (N_CH < NChMin || N_CH > NChMax) begin : g_bad_n_ch
    $error("manager_arbiter: N_CH out of range");
  end

  // First requester strictly after last, ascending with wrap.
  function automatic logic [IDW-1:0] rr_pick(input logic [N_CH-1:0] req,
                                             input logic [IDW-1:0]  last);
    logic [IDW-1:0] pick;
    int             idx;
    pick = last;
    for (int i = N_CH; i >= 1; i--) begin
      idx = (int'(last) + i) % N_CH;
      if (req[idx]) pick = IDW'(idx);
    end
    return pick;
  endfunction

  // ---------------- alloc path ----------------
  logic             a_vld_q, a_vld_d;
  logic [REQ_W-1:0] a_data_q, a_data_d;
  logic [IDW-1:0]   a_last_q, a_last_d;
  logic [IDW-1:0]   a_sel, a_head;
  logic             a_grant, a_full, a_empty, a_pop;

  assign a_sel   = rr_pick(s_req_alloc_vld, a_last_q);
  assign a_grant = (~a_vld_q | m_req_alloc_rdy) & ~a_full & (|s_req_alloc_vld);

  always_comb begin
    s_req_alloc_rdy = '0;
    a_vld_d         = a_vld_q;
    a_data_d        = a_data_q;
    a_last_d        = a_last_q;
    if (a_grant) begin
      s_req_alloc_rdy[a_sel] = 1'b1;
      a_vld_d  = 1'b1;
      a_data_d = s_req_alloc_data[int'(a_sel)*REQ_W +: REQ_W];
      a_last_d = a_sel;
    end else if (m_req_alloc_rdy) begin
      a_vld_d = 1'b0;
    end
  end

  assign m_req_alloc_vld  = a_vld_q;
  assign m_req_alloc_data = a_data_q;

  always_comb begin
    m_rep_alloc_vld = '0;
    if (s_rep_alloc_vld && !a_empty) m_rep_alloc_vld[a_head] = 1'b1;
  end
  assign s_rep_alloc_rdy  = ~a_empty & m_rep_alloc_rdy[a_head];
  assign m_rep_alloc_data = s_rep_alloc_data;
  assign a_pop            = s_rep_alloc_vld & s_rep_alloc_rdy;

  arb_ord_fifo #(
    .Depth (MAX_OUTST),
    .Width (IDW)
  ) u_alloc_ord (
    .clk_i   (i_clk),
    .rst_ni  (i_rst),
    .push_i  (a_grant),
    .data_i  (a_sel),
    .pop_i   (a_pop),
    .full_o  (a_full),
    .empty_o (a_empty),
    .head_o  (a_head)
  );

  // ---------------- dealloc path ----------------
  logic             d_vld_q, d_vld_d;
  logic [REP_W-1:0] d_data_q, d_data_d;
  logic [IDW-1:0]   d_last_q, d_last_d;
  logic [IDW-1:0]   d_sel, d_head;
  logic             d_grant, d_full, d_empty, d_pop;

  assign d_sel   = rr_pick(s_req_dealloc_vld, d_last_q);
  assign d_grant = (~d_vld_q | m_req_dealloc_rdy) & ~d_full & (|s_req_dealloc_vld);

  always_comb begin
    s_req_dealloc_rdy = '0;
    d_vld_d           = d_vld_q;
    d_data_d          = d_data_q;
    d_last_d          = d_last_q;
    if (d_grant) begin
      s_req_dealloc_rdy[d_sel] = 1'b1;
      d_vld_d  = 1'b1;
      d_data_d = s_req_dealloc_data[int'(d_sel)*REP_W +: REP_W];
      d_last_d = d_sel;
    end else if (m_req_dealloc_rdy) begin
      d_vld_d = 1'b0;
    end
  end

  assign m_req_dealloc_vld  = d_vld_q;
  assign m_req_dealloc_data = d_data_q;

  always_comb begin
    m_rep_dealloc_vld = '0;
    if (s_rep_dealloc_vld && !d_empty) m_rep_dealloc_vld[d_head] = 1'b1;
  end
  assign s_rep_dealloc_rdy  = ~d_empty & m_rep_dealloc_rdy[d_head];
  assign m_rep_dealloc_data = s_rep_dealloc_data;
  assign d_pop              = s_rep_dealloc_vld & s_rep_dealloc_rdy;

  arb_ord_fifo #(
    .Depth (MAX_OUTST),
    .Width (IDW)
  ) u_dealloc_ord (
    .clk_i   (i_clk),
    .rst_ni  (i_rst),
    .push_i  (d_grant),
    .data_i  (d_sel),
    .pop_i   (d_pop),
    .full_o  (d_full),
    .empty_o (d_empty),
    .head_o  (d_head)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      a_vld_q  <= 1'b0;
      a_data_q <= '0;
      a_last_q <= LastCh;
      d_vld_q  <= 1'b0;
      d_data_q <= '0;
      d_last_q <= LastCh;
    end else begin
      a_vld_q  <= a_vld_d;
      a_data_q <= a_data_d;
      a_last_q <= a_last_d;
      d_vld_q  <= d_vld_d;
      d_data_q <= d_data_d;
      d_last_q <= d_last_d;
    end
  end

`ifdef MANAGER_ARB_ERR_EN
  logic err_q;

  // A reply with nothing outstanding means the core broke request ordering.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      err_q <= 1'b0;
    end else if ((s_rep_alloc_vld & a_empty) | (s_rep_dealloc_vld & d_empty)) begin
      err_q <= 1'b1;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_manager_arbiter.sv
// Self-checking bench for manager_arbiter: directed scenarios plus random
// traffic, all checked against a queue-based reference model.
module tb_manager_arbiter;

  localparam int N_CH  = 4;
  localparam int W     = 8;
  localparam int DEPTH = 4;
`ifdef MANAGER_ARB_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  logic [N_CH-1:0]   s_req_alloc_vld, s_req_alloc_rdy;
  logic [N_CH*W-1:0] s_req_alloc_data;
  logic [N_CH-1:0]   s_req_dealloc_vld, s_req_dealloc_rdy;
  logic [N_CH*W-1:0] s_req_dealloc_data;
  logic              m_req_alloc_vld, m_req_alloc_rdy;
  logic [W-1:0]      m_req_alloc_data;
  logic              m_req_dealloc_vld, m_req_dealloc_rdy;
  logic [W-1:0]      m_req_dealloc_data;
  logic              s_rep_alloc_vld, s_rep_alloc_rdy;
  logic [W-1:0]      s_rep_alloc_data;
  logic [N_CH-1:0]   m_rep_alloc_vld, m_rep_alloc_rdy;
  logic [W-1:0]      m_rep_alloc_data;
  logic              s_rep_dealloc_vld, s_rep_dealloc_rdy;
  logic [W-1:0]      s_rep_dealloc_data;
  logic [N_CH-1:0]   m_rep_dealloc_vld, m_rep_dealloc_rdy;
  logic [W-1:0]      m_rep_dealloc_data;
  logic              o_err;

  manager_arbiter #(
    .N_CH      (N_CH),
    .REQ_W     (W),
    .REP_W     (W),
    .MAX_OUTST (DEPTH)
  ) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .s_req_alloc_vld    (s_req_alloc_vld),
    .s_req_alloc_rdy    (s_req_alloc_rdy),
    .s_req_alloc_data   (s_req_alloc_data),
    .s_req_dealloc_vld  (s_req_dealloc_vld),
    .s_req_dealloc_rdy  (s_req_dealloc_rdy),
    .s_req_dealloc_data (s_req_dealloc_data),
    .m_req_alloc_vld    (m_req_alloc_vld),
    .m_req_alloc_rdy    (m_req_alloc_rdy),
    .m_req_alloc_data   (m_req_alloc_data),
    .m_req_dealloc_vld  (m_req_dealloc_vld),
    .m_req_dealloc_rdy  (m_req_dealloc_rdy),
    .m_req_dealloc_data (m_req_dealloc_data),
    .s_rep_alloc_vld    (s_rep_alloc_vld),
    .s_rep_alloc_rdy    (s_rep_alloc_rdy),
    .s_rep_alloc_data   (s_rep_alloc_data),
    .m_rep_alloc_vld    (m_rep_alloc_vld),
    .m_rep_alloc_rdy    (m_rep_alloc_rdy),
    .m_rep_alloc_data   (m_rep_alloc_data),
    .s_rep_dealloc_vld  (s_rep_dealloc_vld),
    .s_rep_dealloc_rdy  (s_rep_dealloc_rdy),
    .s_rep_dealloc_data (s_rep_dealloc_data),
    .m_rep_dealloc_vld  (m_rep_dealloc_vld),
    .m_rep_dealloc_rdy  (m_rep_dealloc_rdy),
    .m_rep_dealloc_data (m_rep_dealloc_data),
    .o_err              (o_err)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: per path, last granted channel, the core-side output
  // slot, and the list of channels still waiting for a reply.
  int       last_m [2];
  bit       ov_m   [2];
  bit [7:0] od_m   [2];
  int       qa[$];
  int       qd[$];
  bit       err_m;

  logic [3:0] obs_sreq_rdy [2];
  logic [3:0] obs_mrep_vld [2];
  logic       obs_srep_rdy [2];
  logic       obs_mreq_vld [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int qsize(input int p);
    return (p == 0) ? qa.size() : qd.size();
  endfunction

  function automatic int qfront(input int p);
    return (p == 0) ? qa[0] : qd[0];
  endfunction

  task automatic idle_inputs();
    s_req_alloc_vld    = '0;
    s_req_alloc_data   = '0;
    s_req_dealloc_vld  = '0;
    s_req_dealloc_data = '0;
    m_req_alloc_rdy    = 1'b0;
    m_req_dealloc_rdy  = 1'b0;
    s_rep_alloc_vld    = 1'b0;
    s_rep_alloc_data   = '0;
    m_rep_alloc_rdy    = '0;
    s_rep_dealloc_vld  = 1'b0;
    s_rep_dealloc_data = '0;
    m_rep_dealloc_rdy  = '0;
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      last_m[p] = N_CH - 1;
      ov_m[p]   = 1'b0;
      od_m[p]   = '0;
    end
    qa.delete();
    qd.delete();
    err_m = 1'b0;
  endtask

  // Called at a negedge with inputs already driven; checks, then advances.
  task automatic step();
    logic [3:0]  rv, rr, exp_rdy, exp_rv, g_rdy, g_mrep;
    logic [31:0] dat;
    logic [7:0]  repd, g_md, g_rd;
    logic        crdy, repv, g_mvld, g_srr, exp_srr;
    string       pn;
    int          sel, qs, c;
    bit          can;
    #1;
    check("o_err", {31'b0, o_err}, {31'b0, err_m});
    for (int p = 0; p < 2; p++) begin
      if (p == 0) begin
        pn = "alloc"; rv = s_req_alloc_vld; dat = s_req_alloc_data;
        crdy = m_req_alloc_rdy; repv = s_rep_alloc_vld; rr = m_rep_alloc_rdy;
        repd = s_rep_alloc_data; g_rdy = s_req_alloc_rdy; g_mvld = m_req_alloc_vld;
        g_md = m_req_alloc_data; g_mrep = m_rep_alloc_vld; g_srr = s_rep_alloc_rdy;
        g_rd = m_rep_alloc_data;
      end else begin
        pn = "dealloc"; rv = s_req_dealloc_vld; dat = s_req_dealloc_data;
        crdy = m_req_dealloc_rdy; repv = s_rep_dealloc_vld; rr = m_rep_dealloc_rdy;
        repd = s_rep_dealloc_data; g_rdy = s_req_dealloc_rdy; g_mvld = m_req_dealloc_vld;
        g_md = m_req_dealloc_data; g_mrep = m_rep_dealloc_vld; g_srr = s_rep_dealloc_rdy;
        g_rd = m_rep_dealloc_data;
      end
      qs  = qsize(p);
      can = (!ov_m[p] || crdy) && (qs < DEPTH) && (rv != 0);
      sel = 0;
      for (int i = N_CH; i >= 1; i--) begin
        c = (last_m[p] + i) % N_CH;
        if (rv[c]) sel = c;
      end
      exp_rdy = can ? 4'(1 << sel) : 4'h0;
      exp_rv  = (repv && qs > 0) ? 4'(1 << qfront(p)) : 4'h0;
      exp_srr = (qs > 0) ? rr[qfront(p)] : 1'b0;
      check({pn, "_s_req_rdy"}, {28'b0, g_rdy}, {28'b0, exp_rdy});
      check({pn, "_m_req_vld"}, {31'b0, g_mvld}, {31'b0, ov_m[p]});
      check({pn, "_m_req_data"}, {24'b0, g_md}, {24'b0, od_m[p]});
      check({pn, "_m_rep_vld"}, {28'b0, g_mrep}, {28'b0, exp_rv});
      check({pn, "_s_rep_rdy"}, {31'b0, g_srr}, {31'b0, exp_srr});
      check({pn, "_m_rep_data"}, {24'b0, g_rd}, {24'b0, repd});
      obs_sreq_rdy[p] = g_rdy;
      obs_mrep_vld[p] = g_mrep;
      obs_srep_rdy[p] = g_srr;
      obs_mreq_vld[p] = g_mvld;
      if (ERR_EN && repv && qs == 0) err_m = 1'b1;
      if (repv && exp_srr) begin
        if (p == 0) void'(qa.pop_front()); else void'(qd.pop_front());
      end
      if (can) begin
        ov_m[p]   = 1'b1;
        od_m[p]   = dat[sel*8 +: 8];
        last_m[p] = sel;
        if (p == 0) qa.push_back(sel); else qd.push_back(sel);
      end else if (crdy) begin
        ov_m[p] = 1'b0;
      end
    end
    @(negedge i_clk);
  endtask

  // Asserted off the clock edge so the asynchronous clear is observed directly.
  task automatic do_reset();
    idle_inputs();
    i_rst = 1'b0;
    #1;
    check("rst_m_req_vld", {30'b0, m_req_alloc_vld, m_req_dealloc_vld}, 32'h0);
    check("rst_m_req_data", {16'b0, m_req_alloc_data, m_req_dealloc_data}, 32'h0);
    check("rst_s_req_rdy", {24'b0, s_req_alloc_rdy, s_req_dealloc_rdy}, 32'h0);
    check("rst_m_rep_vld", {24'b0, m_rep_alloc_vld, m_rep_dealloc_vld}, 32'h0);
    check("rst_s_rep_rdy", {30'b0, s_rep_alloc_rdy, s_rep_dealloc_rdy}, 32'h0);
    check("rst_o_err", {31'b0, o_err}, 32'h0);
    model_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && (qa.size() + qd.size() != 0 || ov_m[0] || ov_m[1]); k++) begin
      idle_inputs();
      m_req_alloc_rdy   = 1'b1;
      m_req_dealloc_rdy = 1'b1;
      s_rep_alloc_vld   = (qa.size() > 0);
      s_rep_dealloc_vld = (qd.size() > 0);
      s_rep_alloc_data  = 8'($urandom);
      s_rep_dealloc_data = 8'($urandom);
      m_rep_alloc_rdy   = '1;
      m_rep_dealloc_rdy = '1;
      step();
    end
    check("drain_done", qa.size() + qd.size(), 0);
    idle_inputs();
  endtask

  logic [3:0] gseq [5];

  initial begin
    gseq = '{4'h1, 4'h4, 4'h1, 4'h4, 4'h0};
    idle_inputs();
    i_rst = 1'b1;
    @(negedge i_clk);
    do_reset();
    step();

    // Channels 0 and 2 contend; ordering FIFO fills after four grants.
    for (int k = 0; k < 5; k++) begin
      idle_inputs();
      s_req_alloc_vld  = 4'b0101;
      s_req_alloc_data = $urandom;
      m_req_alloc_rdy  = 1'b1;
      step();
      check($sformatf("rr_grant_%0d", k), {28'b0, obs_sreq_rdy[0]}, {28'b0, gseq[k]});
    end
    drain();

    // Core stalls with 0x5A in the output slot; ch3 must wait.
    s_req_alloc_vld  = 4'b0010;
    s_req_alloc_data = 32'h0000_5A00;
    step();
    for (int k = 0; k < 3; k++) begin
      s_req_alloc_vld  = 4'b1000;
      s_req_alloc_data = 32'h7700_0000;
      m_req_alloc_rdy  = 1'b0;
      step();
      check("hold_data", {24'b0, m_req_alloc_data}, 32'h5A);
      check("hold_rdy", {28'b0, obs_sreq_rdy[0]}, 32'h0);
    end
    m_req_alloc_rdy = 1'b1;
    step();
    check("unstall_grant", {28'b0, obs_sreq_rdy[0]}, 32'h8);
    drain();

    // Reply steering: ch1 then ch3, ch1 initially not ready.
    m_req_alloc_rdy = 1'b1;
    s_req_alloc_vld = 4'b0010;
    step();
    s_req_alloc_vld = 4'b1000;
    step();
    idle_inputs();
    s_rep_alloc_vld  = 1'b1;
    s_rep_alloc_data = 8'h11;
    m_rep_alloc_rdy  = 4'b1101;
    step();
    check("steer_stall_rdy", {31'b0, obs_srep_rdy[0]}, 32'h0);
    check("steer_vld1", {28'b0, obs_mrep_vld[0]}, 32'h2);
    m_rep_alloc_rdy = 4'hF;
    step();
    s_rep_alloc_data = 8'h22;
    step();
    check("steer_vld3", {28'b0, obs_mrep_vld[0]}, 32'h8);
    drain();

    // Both paths at once, replies routed independently.
    s_req_alloc_vld   = 4'b0001;
    s_req_dealloc_vld = 4'b0010;
    s_req_alloc_data  = $urandom;
    s_req_dealloc_data = $urandom;
    m_req_alloc_rdy   = 1'b1;
    m_req_dealloc_rdy = 1'b1;
    step();
    idle_inputs();
    s_rep_alloc_vld   = 1'b1;
    s_rep_dealloc_vld = 1'b1;
    m_rep_alloc_rdy   = 4'hF;
    m_rep_dealloc_rdy = 4'hF;
    step();
    check("dual_m_req_vld", {30'b0, obs_mreq_vld[0], obs_mreq_vld[1]}, 32'h3);
    check("dual_rep_a", {28'b0, obs_mrep_vld[0]}, 32'h1);
    check("dual_rep_d", {28'b0, obs_mrep_vld[1]}, 32'h2);
    drain();

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      s_req_alloc_vld    = 4'($urandom);
      s_req_alloc_data   = $urandom;
      s_req_dealloc_vld  = 4'($urandom);
      s_req_dealloc_data = $urandom;
      m_req_alloc_rdy    = ($urandom_range(0, 3) != 0);
      m_req_dealloc_rdy  = ($urandom_range(0, 3) != 0);
      s_rep_alloc_vld    = (qa.size() > 0) && ($urandom_range(0, 1) == 1);
      s_rep_dealloc_vld  = (qd.size() > 0) && ($urandom_range(0, 1) == 1);
      s_rep_alloc_data   = 8'($urandom);
      s_rep_dealloc_data = 8'($urandom);
      m_rep_alloc_rdy    = 4'($urandom);
      m_rep_dealloc_rdy  = 4'($urandom);
      step();
    end
    drain();

    // Stray dealloc reply with nothing outstanding.
    s_rep_dealloc_vld = 1'b1;
    m_rep_dealloc_rdy = 4'hF;
    step();
    check("stray_rdy", {31'b0, obs_srep_rdy[1]}, 32'h0);
    idle_inputs();
    step();
    check("stray_err", {31'b0, o_err}, {31'b0, ERR_EN});

    // Reset in the middle of traffic.
    for (int k = 0; k < 3; k++) begin
      s_req_alloc_vld   = 4'($urandom) | 4'h1;
      s_req_dealloc_vld = 4'($urandom) | 4'h2;
      s_req_alloc_data  = $urandom;
      s_req_dealloc_data = $urandom;
      step();
    end
    do_reset();
    step();
    s_req_alloc_vld = 4'b0101;
    m_req_alloc_rdy = 1'b1;
    step();
    check("post_rst_grant", {28'b0, obs_sreq_rdy[0]}, 32'h1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/manager_arbiter.md
# manager_arbiter

Shares one page-allocator core between `N_CH` manager channels. Two independent round-robin arbiters, one for alloc requests and one for dealloc requests, merge the channels' request FIFO outputs into single core request streams. In-order ordering FIFOs record which channel issued each request, so core replies are steered back to the originating channel's reply FIFO. The block sits between the per-channel request/reply buffers and the allocator core.

## Interface
- `N_CH`, 4, number of manager channels (2..16)
- `REQ_W`, 8, alloc request payload width
- `REP_W`, 8, dealloc request and all reply payload width
- `MAX_OUTST`, 4, outstanding requests tracked per path; ordering FIFO depth (power of 2)
- `i_clk`  in  1  clock, all logic rising-edge
- `i_rst`  in  1  reset, asynchronous, active-low
- `s_req_alloc_vld` / `_rdy`  in / out  N_CH  per-channel alloc request handshake
- `s_req_alloc_data`  in  N_CH*REQ_W  channel k at bits [k*REQ_W +: REQ_W]
- `s_req_dealloc_vld` / `_rdy`  in / out  N_CH  per-channel dealloc request handshake
- `s_req_dealloc_data`  in  N_CH*REP_W  packed as above
- `m_req_alloc_vld` / `_rdy` / `_data`  out / in / out  1 / 1 / REQ_W  to core
- `m_req_dealloc_vld` / `_rdy` / `_data`  out / in / out  1 / 1 / REP_W  to core
- `s_rep_alloc_vld` / `_rdy` / `_data`  in / out / in  1 / 1 / REP_W  from core
- `m_rep_alloc_vld` / `_rdy`  out / in  N_CH  per-channel alloc reply handshake
- `m_rep_alloc_data`  out  REP_W  broadcast to all channels
- `s_rep_dealloc_*`, `m_rep_dealloc_*`  same shape as the alloc reply ports
- `o_err`  out  1  sticky protocol-error flag

## Operation
- Alloc and dealloc paths are identical and independent. Description below is per path.
- Output register: one entry `{vld, data}` drives `m_req_*`.
- Grant condition in a cycle:
  - output register is empty, or it is draining this cycle (`m_vld & m_rdy`), and
  - the ordering FIFO is not full, and
  - at least one `s_req_vld` is set.
- Grant selection: first requesting channel strictly after `last_grant`, in ascending order with wrap. `s_req_rdy[k]` = 1 only for the granted channel; all others are 0.
- On the upstream handshake:
  - data is loaded into the output register,
  - channel ID (`$clog2(N_CH)` bits, minimum 1) is pushed into the ordering FIFO,
  - `last_grant` is set to k.
- Reply steering is combinational:
  - `m_rep_vld[k] = s_rep_vld & !ord_empty & (ord_head == k)`
  - `s_rep_rdy = !ord_empty & m_rep_rdy[ord_head]`
  - FIFO pops on the `s_rep` handshake.
- The core replies in request order per path; the block relies on this.
- Reply with empty ordering FIFO: `s_rep_rdy` stays 0 (stall) and `o_err` sets (see Configuration).
- Full FIFO: no grant, even if a pop occurs the same cycle. Push and pop in the same cycle when not full is allowed. No empty-bypass: a reply can never pop an ID pushed in the same cycle.

## Timing
- Reset values:
  - `m_req_*_vld` = 0, `m_req_*_data` = 0
  - all `s_req_*_rdy` = 0
  - FIFOs empty, so `s_rep_*_rdy` = 0 and `m_rep_*_vld` = 0
  - `last_grant` = N_CH-1, so channel 0 wins first
  - `o_err` = 0
- Request latency: upstream handshake in cycle t gives `m_req_vld` = 1 in cycle t+1.
- Throughput: 1 request per cycle per path while core `rdy` = 1 and the FIFO is not full.
- AXIS rule: `m_req_vld` / `data` are held stable until `m_req_rdy`.
- Reply latency: 0 cycles (combinational pass-through).
- Reset asserted mid-operation: all state is cleared immediately. In-flight requests and FIFO contents are discarded.

## Configuration
- `MANAGER_ARB_ERR_EN` defined:
  - `o_err` sets when `s_rep_vld` = 1 with the ordering FIFO empty, on either path.
  - It clears only on reset.
- Not defined: `o_err` is tied to 0 and the detection logic is absent. The stall behaviour is unchanged.

## Structure
- Shared package `manager_pkg`:
  - channel-ID width function `ch_id_w(N_CH)`
  - the `N_CH` range limits
- One sub-module, `arb_ord_fifo`: parameterised depth/width, synchronous push/pop, `full` / `empty` / `head` outputs, async active-low reset.
  - Instantiated twice: alloc path and dealloc path.
- Round-robin selection is a function inside `manager_arbiter`; it is not a separate module.

## Test plan
- Reset: after `i_rst` = 0 then release, all `vld` / `rdy` = 0 and `o_err` = 0; first grant with channels 0 and 2 requesting goes to 0.
- Channels 0 and 2 hold alloc `vld`, core `rdy` = 1, no replies, `MAX_OUTST` = 4 → grants 0,2,0,2; `m_req_alloc_vld` one cycle after each; fifth request blocked (FIFO full).
- Core `m_req_alloc_rdy` = 0 with data 0x5A loaded → `m_req_alloc_data` stays 0x5A; all `s_req_alloc_rdy` = 0 until drain.
- Requests from ch1 then ch3; core replies 0x11 then 0x22 → 0x11 on `m_rep_alloc_vld[1]`, then 0x22 on `[3]`; with `m_rep_alloc_rdy[1]` = 0, `s_rep_alloc_rdy` = 0.
- Simultaneous alloc (ch0) and dealloc (ch1) requests → both core ports are valid in the same cycle; replies route independently.
- Stray dealloc reply with empty FIFO → `s_rep_dealloc_rdy` = 0; `o_err` = 1 with `MANAGER_ARB_ERR_EN`, 0 without; reset mid-stream clears all state.
